// File: rtl/fad_bist_if.sv
// rtl/fad_bist_if.sv - bus between the full-adder BIST engine and its controller/adder
// master is the engine side; slave is the controller and attached adder.
interface fad_bist_if;
   logic       start;
   logic       dut_a;
   logic       dut_b;
   logic       dut_cin;
   logic       dut_sum;
   logic       dut_cout;
   logic       busy;
   logic       done;
   logic       pass;
   logic [3:0] err_count;
   logic       fail_valid;
   logic [2:0] first_fail_vec;

   modport master (
      input  start, dut_sum, dut_cout,
      output dut_a, dut_b, dut_cin, busy, done, pass, err_count, fail_valid, first_fail_vec
   );

   modport slave (
      output start, dut_sum, dut_cout,
      input  dut_a, dut_b, dut_cin, busy, done, pass, err_count, fail_valid, first_fail_vec
   );
endinterface

// File: rtl/fad_bist.sv
// rtl/fad_bist.sv - built-in self test for a 1-bit full adder
// Steps {a,b,cin} through 000..111, samples the adder after a settle interval, records errors.
module fad_bist #(
   parameter int unsigned SETTLE_CYCLES = 2
) (
   input  logic          clk,
   input  logic          rst_n,
   fad_bist_if.master    bus
);
   typedef enum logic [1:0] {IDLE, APPLY, CHECK, DONE} state_t;

   // With no settle cycles the APPLY state is bypassed entirely.
   localparam state_t     VEC_ENTRY   = (SETTLE_CYCLES == 0) ? CHECK : APPLY;
   localparam logic [3:0] SETTLE_LAST = 4'((SETTLE_CYCLES == 0) ? 0 : SETTLE_CYCLES - 1);

   state_t     state_q;
   logic [2:0] vec_q;
   logic [3:0] settle_q;
   logic       busy_q;
   logic       done_q;
   logic       pass_q;
   logic [3:0] err_q;
   logic [3:0] err_d;
   logic       fail_valid_q;
   logic [2:0] ffv_q;
   logic       exp_sum;
   logic       exp_cout;
   logic       mismatch;

   always_comb begin
      exp_sum  = ^vec_q;
      exp_cout = (vec_q[2] & vec_q[1]) | (vec_q[2] & vec_q[0]) | (vec_q[1] & vec_q[0]);
      mismatch = (bus.dut_sum != exp_sum) || (bus.dut_cout != exp_cout);
      err_d    = err_q;
      if (mismatch && (err_q != 4'd8)) begin
         err_d = err_q + 4'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         vec_q        <= 3'd0;
         settle_q     <= 4'd0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         pass_q       <= 1'b0;
         err_q        <= 4'd0;
         fail_valid_q <= 1'b0;
         ffv_q        <= 3'd0;
      end else begin
         case (state_q)
            IDLE, DONE: begin
               if (bus.start) begin
                  state_q      <= VEC_ENTRY;
                  vec_q        <= 3'd0;
                  settle_q     <= 4'd0;
                  busy_q       <= 1'b1;
                  done_q       <= 1'b0;
                  pass_q       <= 1'b0;
                  err_q        <= 4'd0;
                  fail_valid_q <= 1'b0;
                  ffv_q        <= 3'd0;
               end
            end
            APPLY: begin
               if (settle_q == SETTLE_LAST) begin
                  settle_q <= 4'd0;
                  state_q  <= CHECK;
               end else begin
                  settle_q <= settle_q + 4'd1;
               end
            end
            CHECK: begin
               err_q <= err_d;
               if (mismatch && !fail_valid_q) begin
                  fail_valid_q <= 1'b1;
                  ffv_q        <= vec_q;
               end
               // Operands return to zero in DONE so the adder sees a quiet input.
               if (vec_q == 3'd7) begin
                  state_q <= DONE;
                  vec_q   <= 3'd0;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  pass_q  <= (err_d == 4'd0);
               end else begin
                  vec_q   <= vec_q + 3'd1;
                  state_q <= VEC_ENTRY;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.dut_a          = vec_q[2];
   assign bus.dut_b          = vec_q[1];
   assign bus.dut_cin        = vec_q[0];
   assign bus.busy           = busy_q;
   assign bus.done           = done_q;
   assign bus.pass           = pass_q;
   assign bus.err_count      = err_q;
   assign bus.fail_valid     = fail_valid_q;
   assign bus.first_fail_vec = ffv_q;
endmodule

// File: tb/tb_fad_bist.sv
// tb/tb_fad_bist.sv - self-checking bench for fad_bist with a table-driven adder model
// Two engines (settle 2 and settle 0) share one fault-injectable adder table.
module tb_fad_bist;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   fad_bist_if bus2 ();
   fad_bist_if bus0 ();

   fad_bist #(.SETTLE_CYCLES(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));
   fad_bist #(.SETTLE_CYCLES(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));

   // Attached adder: entry v holds {cout,sum} for input {a,b,cin}=v.
   logic [15:0] tab;
   logic [2:0]  idx2, idx0;
   assign idx2 = {bus2.dut_a, bus2.dut_b, bus2.dut_cin};
   assign idx0 = {bus0.dut_a, bus0.dut_b, bus0.dut_cin};
   assign {bus2.dut_cout, bus2.dut_sum} = tab[{idx2, 1'b0} +: 2];
   assign {bus0.dut_cout, bus0.dut_sum} = tab[{idx0, 1'b0} +: 2];

   logic start2 = 1'b0;
   logic start0 = 1'b0;
   assign bus2.start = start2;
   assign bus0.start = start0;

   logic        sel = 1'b0;
   logic        s_busy, s_done, s_pass, s_fv;
   logic [3:0]  s_err;
   logic [2:0]  s_ffv, s_vec;
   assign s_busy = sel ? bus0.busy : bus2.busy;
   assign s_done = sel ? bus0.done : bus2.done;
   assign s_pass = sel ? bus0.pass : bus2.pass;
   assign s_fv   = sel ? bus0.fail_valid : bus2.fail_valid;
   assign s_err  = sel ? bus0.err_count : bus2.err_count;
   assign s_ffv  = sel ? bus0.first_fail_vec : bus2.first_fail_vec;
   assign s_vec  = sel ? idx0 : idx2;

   logic [13:0] all2, all0;
   assign all2 = {bus2.busy, bus2.done, bus2.pass, bus2.fail_valid, bus2.err_count, bus2.first_fail_vec, idx2};
   assign all0 = {bus0.busy, bus0.done, bus0.pass, bus0.fail_valid, bus0.err_count, bus0.first_fail_vec, idx0};

   int errors = 0;
   int checks = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // mode 0 correct, 1 sum stuck at 0, 2 cout inverted, 3 random corruption
   task automatic set_mode(input int mode);
      logic [7:0] smask, cmask;
      int s;
      smask = 8'($urandom);
      cmask = 8'($urandom) & 8'($urandom);
      for (int v = 0; v < 8; v++) begin
         s = ((v >> 2) & 1) + ((v >> 1) & 1) + (v & 1);
         case (mode)
            1:       tab[2*v +: 2] = {s[1], 1'b0};
            2:       tab[2*v +: 2] = {~s[1], s[0]};
            3:       tab[2*v +: 2] = 2'(s) ^ {cmask[v], smask[v]};
            default: tab[2*v +: 2] = 2'(s);
         endcase
      end
   endtask

   task automatic run_and_check(input logic which, input int settle, input bit poke,
                                output int got_err, output int got_ffv);
      int per, exp_err, exp_ffv, done_at, vec_bad, s, j;
      per = settle + 1;
      exp_err = 0;
      exp_ffv = 0;
      for (int v = 0; v < 8; v++) begin
         s = ((v >> 2) & 1) + ((v >> 1) & 1) + (v & 1);
         if (tab[2*v +: 2] != 2'(s)) begin
            if (exp_err == 0) exp_ffv = v;
            exp_err++;
         end
      end
      sel = which;
      @(negedge clk);
      if (which) start0 = 1'b1; else start2 = 1'b1;
      @(negedge clk);
      start0 = 1'b0;
      start2 = 1'b0;
      check("start_ack", {s_busy, s_done, s_vec}, {1'b1, 1'b0, 3'd0});
      done_at = -1;
      vec_bad = 0;
      for (j = 0; j < 8 * per + 10; j++) begin
         if (s_done) begin
            done_at = j;
            break;
         end
         if (!s_busy || (32'(s_vec) != 32'(j / per))) vec_bad++;
         if (poke && j == 3 * per) begin
            if (which) start0 = 1'b1; else start2 = 1'b1;
         end else begin
            start0 = 1'b0;
            start2 = 1'b0;
         end
         @(negedge clk);
      end
      start0 = 1'b0;
      start2 = 1'b0;
      check("done_latency", done_at, 8 * per);
      check("vector_walk", vec_bad, 0);
      check("err_count", s_err, exp_err);
      check("first_fail_vec", s_ffv, exp_ffv);
      check("fail_valid", s_fv, exp_err != 0);
      check("pass", s_pass, exp_err == 0);
      check("done_idle_outs", {s_busy, s_vec}, 4'd0);
      got_err = 32'(s_err);
      got_ffv = 32'(s_ffv);
   endtask

   initial begin
      int e, f;
      set_mode(0);
      repeat (3) @(negedge clk);
      check("reset_outs2", all2, 0);
      check("reset_outs0", all0, 0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      check("idle_outs", {all2, all0}, 0);

      run_and_check(1'b0, 2, 1'b0, e, f);
      check("good_err", e, 0);

      set_mode(1);
      run_and_check(1'b0, 2, 1'b0, e, f);
      check("stuck0_err", e, 4);
      check("stuck0_ffv", f, 1);

      set_mode(2);
      run_and_check(1'b0, 2, 1'b0, e, f);
      check("coutinv_err", e, 8);
      check("coutinv_ffv", f, 0);

      set_mode(1);
      run_and_check(1'b0, 2, 1'b1, e, f);
      run_and_check(1'b0, 2, 1'b0, e, f);
      check("restart_err", e, 4);

      for (int i = 0; i < 6; i++) begin
         set_mode(3);
         run_and_check(1'(i & 1), (i & 1) ? 0 : 2, 1'b0, e, f);
      end

      set_mode(0);
      run_and_check(1'b1, 0, 1'b0, e, f);

      sel = 1'b0;
      @(negedge clk);
      start2 = 1'b1;
      @(negedge clk);
      start2 = 1'b0;
      repeat (15) @(negedge clk);
      check("mid_run_vec5", {bus2.busy, idx2}, {1'b1, 3'd5});
      #2 rst_n = 1'b0;
      #1;
      check("async_reset2", all2, 0);
      check("async_reset0", all0, 0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      check("stay_idle", {all2, all0}, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/fad_bist.md
# fad_bist

Self-checking built-in test engine for the lab's 1-bit full adder. It drives all eight `{a, b, cin}` combinations into an attached full adder in the fixed ascending order 000 through 111. After a programmable settle interval it samples the adder's `sum` and `cout` and compares them against the expected values. It reports pass/fail, the mismatch count and the first failing vector, so the adder can be checked on the board without a simulator.

## Interface
Parameters:
- SETTLE_CYCLES, default 2: extra cycles each vector is held before sampling; legal range 0..15.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  begin a run; sampled only in IDLE or DONE.
- dut_a  out  1  adder operand a; registered.
- dut_b  out  1  adder operand b; registered.
- dut_cin  out  1  adder carry-in; registered.
- dut_sum  in  1  adder sum; combinational from the adder.
- dut_cout  in  1  adder carry-out; combinational from the adder.
- busy  out  1  high while a run is in progress.
- done  out  1  high from the end of a run until the next accepted start or reset.
- pass  out  1  valid while done; 1 when err_count == 0.
- err_count  out  4  number of mismatching vectors in the run, 0..8.
- fail_valid  out  1  at least one mismatch has been recorded in the run.
- first_fail_vec  out  3  `{a,b,cin}` of the first mismatching vector.

## Operation
- Vector index v[2:0] maps to `{dut_a, dut_b, dut_cin}`.
- Expected values:
  - sum = a ^ b ^ cin
  - cout = a&b | a&cin | b&cin
- A vector is a mismatch if either output differs. The count is per vector, not per bit.
- FSM states: IDLE, APPLY, CHECK, DONE.
  - IDLE: outputs zero. start=1 → APPLY, v=0, clear err_count, fail_valid, first_fail_vec, pass.
  - APPLY: hold v; settle counter counts SETTLE_CYCLES cycles → CHECK. With SETTLE_CYCLES=0, APPLY is skipped and CHECK is entered directly.
  - CHECK: one cycle. At its closing edge, compare dut_sum/dut_cout with the expected values.
    - On mismatch: increment err_count. If fail_valid=0, set fail_valid=1 and first_fail_vec=v.
    - If v==7 → DONE; otherwise v+1 → APPLY (or CHECK if SETTLE_CYCLES=0).
  - DONE: done=1, busy=0, dut_* driven to 0. pass = (final err_count == 0). start=1 → restart exactly as from IDLE, with done cleared.
- start is ignored while busy.
- err_count cannot wrap; 8 is the maximum value.
- Reset (asynchronous, any state, including mid-run) forces IDLE. All outputs go to 0: dut_a, dut_b, dut_cin, busy, done, pass, err_count, fail_valid, first_fail_vec.

## Timing
- start is sampled high at edge E0.
  - From E0: busy=1 and dut_* = 000.
  - Each vector is held for SETTLE_CYCLES+1 cycles.
  - The result of vector v is registered at edge E0 + (v+1)(SETTLE_CYCLES+1).
- done rises, and busy falls, at edge E0 + 8(SETTLE_CYCLES+1). This is 24 cycles at the default.
- err_count, pass and first_fail_vec are stable on the same edge that done rises.
- dut_* change only at vector boundaries, so they are glitch-free relative to clk.
- The adder path from dut_* to dut_sum/dut_cout must settle within (SETTLE_CYCLES+1) clock periods.

## Test plan
- Correct adder model, SETTLE_CYCLES=2, pulse start → done rises 24 cycles later; pass=1, err_count=0, fail_valid=0; dut_* step through 000..111.
- sum stuck at 0 → mismatches on vectors 1, 2, 4, 7; err_count=4, first_fail_vec=3'b001, pass=0.
- cout inverted → err_count=8, first_fail_vec=3'b000, fail_valid=1, pass=0.
- start pulsed again while busy at vector 3 → ignored; run completes on schedule; then start in DONE → done clears next cycle and a fresh run repeats the same results.
- rst_n asserted low mid-run at vector 5, asynchronous to clk → all outputs 0 immediately; after release with no start, the block stays in IDLE.
- SETTLE_CYCLES=0 with a correct model → each vector held 1 cycle; done 8 cycles after start; pass=1.
